// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix step.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_main, neg_rem;

  logic               op_mul, op_div, op_signed, div_zero, accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign div_zero  = op_div && (b == '0);
  assign accept    = (state == S_IDLE) && start && !flush && (op_mul || op_div);
  assign a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, opnd};
  assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_main ? -acc : acc;
  assign q_fix    = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = div_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  assign stall = ((state == S_IDLE) && start && (op_mul || op_div) && !div_zero) ||
                 (state == S_CALC) || (state == S_FIX);
  assign done      = (state == S_DONE) && !flush;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            is_div   <= op_div;
            neg_main <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= op_signed && a[WIDTH-1];
            opnd     <= op_div ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
          end
          if (start && op == OP_MTHI) hi <= a;
          if (start && op == OP_MTLO) lo <= a;
        end
        S_CALC: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: table of directed vectors, hand-written flush/reset/MTHI/MTLO
// sequences and random operations checked against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic         clk, rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         stall, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_hi, cur_lo;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t tbl[10];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // reference model
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
    longint sa, sb, q, r;
    eh = cur_hi;
    el = cur_lo;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      OP_MULTU: begin p = {32'b0, av} * {32'b0, bv}; eh = p[63:32]; el = p[31:0]; end
      OP_DIV:   if (bv != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      OP_DIVU:  if (bv != 0) begin el = av / bv; eh = av % bv; end
      default: ;
    endcase
  endtask

  // driver: issue one multi-cycle op, hold start until done, check timing and result
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int exp_done, input int exp_stall, input string name);
    int cyc, stall_cnt, done_cyc;
    logic [W-1:0] qh, ql;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    cyc = 0; stall_cnt = 0; done_cyc = -1;
    while (cyc < 3 * W) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, " done_cycle"}, W'(done_cyc), W'(exp_done));
    chk({name, " stall_cycles"}, W'(stall_cnt), W'(exp_stall));
    qh = exp_q.pop_front();
    ql = exp_q.pop_front();
    if (done_cyc >= 0) begin
      chk({name, " hi"}, hi, qh);
      chk({name, " lo"}, lo, ql);
    end
    cur_hi = qh;
    cur_lo = ql;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    #1;
    chk({name, " single_done"}, W'(done), W'(0));
    chk({name, " no_reaccept"}, W'(stall), W'(0));
  endtask

  initial begin
    logic [W-1:0] eh, el, av, bv;
    logic [2:0]   o;
    int seen_done;

    tbl[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    tbl[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    tbl[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    tbl[7] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    tbl[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[9] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    chk("reset stall", W'(stall), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset state", W'(dbg_state), W'(0));

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, W + 2, W + 2,
             $sformatf("vec%0d", i));

    // divide by zero: immediate done, no stall, HI/LO untouched
    run_op(OP_DIVU, 32'd100, 32'd0, cur_hi, cur_lo, 1, 0, "divu_by_zero");

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h12345678;
    #1 chk("mthi stall", W'(stall), W'(0));
    @(negedge clk);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi done", W'(done), W'(0));
    op = OP_MTLO; a = 32'h9ABCDEF0;
    #1 chk("mtlo stall", W'(stall), W'(0));
    @(negedge clk);
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo done", W'(done), W'(0));
    start = 1'b0; op = 3'b000;
    cur_hi = 32'h12345678; cur_lo = 32'h9ABCDEF0;

    // flush a divide in cycle 15
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      #1 if (done) seen_done++;
    end
    flush = 1'b1; start = 1'b0; op = 3'b000;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush idle", W'(dbg_state), W'(0));
    chk("flush stall", W'(stall), W'(0));
    repeat (W + 4) begin
      @(negedge clk);
      #1 if (done) seen_done++;
    end
    chk("flush no_done", W'(seen_done), W'(0));
    chk("flush hi kept", hi, cur_hi);
    chk("flush lo kept", lo, cur_lo);

    // flush together with MTLO: no write
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; op = 3'b000;
    #1 chk("flush_mtlo lo", lo, cur_lo);

    // random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      o  = 3'($urandom_range(1, 4));
      av = $urandom;
      bv = $urandom;
      if (i % 2 == 1) bv = W'($urandom_range(1, 300));
      if (bv == '0) bv = 32'd1;
      model(o, av, bv, eh, el);
      run_op(o, av, bv, eh, el, W + 2, W + 2, $sformatf("rand%0d", i));
    end

    // asynchronous reset in cycle 10 of a multiply
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'h0000FFFF; b = 32'h00001234;
    repeat (10) @(negedge clk);
    #1 chk("pre_rst stall", W'(stall), W'(1));
    rst = 1'b1; start = 1'b0; op = 3'b000;
    #1;
    chk("rst_calc state", W'(dbg_state), W'(0));
    chk("rst_calc hi", hi, '0);
    chk("rst_calc lo", lo, '0);
    chk("rst_calc stall", W'(stall), W'(0));
    chk("rst_calc done", W'(done), W'(0));
    @(negedge clk);
    rst = 1'b0;
    cur_hi = '0; cur_lo = '0;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, W + 2, W + 2, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the single-cycle ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run as iterative shift-add / restoring-division sequences and stall the pipeline until the result is written. MTHI/MTLO complete in one cycle without stalling.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request valid; held by EX until `stall` drops
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  synchronous abort from exception/branch logic
- stall  out  1  combinational pipeline stall request
- done  out  1  one-cycle pulse: result written to HI/LO
- hi  out  WIDTH  HI register: product upper half, or remainder
- lo  out  WIDTH  LO register: product lower half, or quotient

## Operation
- States: IDLE, CALC, FIX, DONE. Iteration counter is $clog2(WIDTH)+1 bits wide.
- **IDLE**
  - start=1 with op MULT/MULTU/DIV/DIVU:
    - Latch |a| and |b|. Signed ops take absolute value; unsigned ops use the raw value.
    - Latch the result signs: product sign = a[W-1]^b[W-1]; quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1]. Signs are 0 for unsigned ops.
    - Clear the counter and go to CALC.
  - DIV/DIVU with b==0: go directly to DONE. HI/LO stay unchanged.
  - start=1 with op MTHI: hi<=a. With op MTLO: lo<=a. Both complete on that edge; stay in IDLE; done stays 0.
  - op none, or start=0: no action.
- **CALC**: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: 2W-bit shift-add over the W multiplier bits.
  - Divide: restoring division, one quotient bit per cycle.
- **FIX**
  - Apply two's-complement negation where the latched sign is 1: to the 2W-bit product for multiply; separately to quotient and remainder for divide.
  - Write hi/lo, then go to DONE.
- **DONE**: done=1; start is ignored; go to IDLE next edge.
- Signed divide truncates toward zero; the remainder takes the dividend's sign.
- MIN/-1: lo=MIN, hi=0. This falls out naturally and needs no special case.
- `stall` = (state==IDLE & start & op∈{MULT,MULTU,DIV,DIVU} & !(div-by-zero)) | state==CALC | state==FIX.
  - Div-by-zero: stall=0 in the accept cycle. Software must not rely on that result.
- **flush** (synchronous)
  - Any state goes to IDLE. HI/LO are not written; done=0.
  - Flush in the same cycle as start in IDLE: flush wins, the request is not accepted, and MTHI/MTLO do not write.
- **rst** (asynchronous): state=IDLE, counter=0, hi=0, lo=0, done=0, internal operand/accumulator registers=0. Takes effect immediately in any state.

## Timing
- Cycle 0 = the cycle in which start is sampled in IDLE; accept edge E0 ends it.
- Multiply/divide:
  - stall is high in cycles 0 through W+1.
  - CALC occupies cycles 1..W; FIX is cycle W+1.
  - HI/LO update on the edge ending cycle W+1.
  - done=1 and stall=0 in cycle W+2. For W=32: done in cycle 34.
  - Back-to-back requests: a new start is accepted earliest in cycle W+3.
- Div-by-zero: done=1 in cycle 1, stall=0 throughout.
- MTHI/MTLO: new value visible in cycle 1, stall=0.
- hi/lo are registered outputs and never change outside FIX, MTHI/MTLO, or rst.

## Test plan
- Reset mid-CALC (rst at cycle 10) → immediate IDLE, hi=lo=0, stall=0, done=0.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, W=32 → stall cycles 0–33; done only in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=100 b=0 → done in cycle 1, HI/LO unchanged, stall never high.
- MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 → hi/lo updated one cycle after each, no stall, no done. Flush at cycle 15 of a DIVU → IDLE, HI/LO retain 0x12345678/0x9ABCDEF0, no done.
- Flush and start together in IDLE with MTLO → lo unchanged. Request held through DONE → exactly one done pulse, no re-accept in the DONE cycle.
